// File: rtl/rr_storage_pkg.sv
// Shared types and constants for the record-mode storage backend.
package rr_storage_pkg;

    localparam int unsigned RR_ADDR_W     = 64;
    localparam int unsigned RR_SIZE_W     = 32;
    localparam int unsigned RR_BEAT_BYTES = 64;

    // Host buffer descriptor as held in the descriptor queue.
    typedef struct packed {
        logic [RR_ADDR_W-1:0] addr;
        logic [RR_SIZE_W-1:0] size;
    } rr_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACTIVE,
        ST_RETIRE
    } rr_state_t;

    // Round a byte count down to a whole number of write beats.
    function automatic logic [RR_SIZE_W-1:0] rr_beat_trunc(input logic [RR_SIZE_W-1:0] s);
        return s & ~RR_SIZE_W'(RR_BEAT_BYTES - 1);
    endfunction

endpackage

// File: rtl/rr_desc_fifo.sv
// Register-based first-word-fall-through descriptor FIFO with synchronous clear.
module rr_desc_fifo
    import rr_storage_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  rr_desc_t               din,
    input  logic                   pop,
    output rr_desc_t               dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rr_desc_t         mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign dout  = mem[rd_ptr];

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; clear drops stored entries but keeps a same-cycle push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (clear) begin
                rd_ptr <= wr_ptr;
                count  <= CNT_W'(wr_en);
            end else begin
                if (rd_en) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (wr_en && !rd_en) begin
                    count <= count + CNT_W'(1);
                end else if (!wr_en && rd_en) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rr_buf_desc_sched.sv
// Host-buffer descriptor scheduler: queues descriptors, feeds the writeback engine, retires buffers.
module rr_buf_desc_sched
    import rr_storage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned SIZE_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    input  logic [ADDR_WIDTH-1:0]  desc_addr,
    input  logic [SIZE_WIDTH-1:0]  desc_size,
    output logic [ADDR_WIDTH-1:0]  buf_addr,
    output logic [SIZE_WIDTH-1:0]  buf_size,
    output logic                   buf_update,
    input  logic                   beat_done,
    input  logic                   finish,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic [ADDR_WIDTH-1:0]  done_addr,
    output logic [SIZE_WIDTH-1:0]  done_bytes,
    output logic                   done_last,
    output logic                   irq,
    output logic                   stall,
    output logic                   err_overrun,
    output logic [$clog2(DEPTH):0] q_count
);

    rr_state_t             state;
    rr_desc_t              cur;
    rr_desc_t              head;
    rr_desc_t              in_desc;
    logic                  fin_pend;
    logic                  fin_now;
    logic [SIZE_WIDTH-1:0] cnt;
    logic [SIZE_WIDTH-1:0] cnt_next;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_clear;
    logic                  push_acc;
    logic                  bypass;

    assign in_desc.addr = RR_ADDR_W'(desc_addr);
    assign in_desc.size = rr_beat_trunc(RR_SIZE_W'(desc_size));

    assign desc_ready = ~fifo_full;
    assign push_acc   = desc_valid & ~fifo_full;
    // A push into an empty queue while idle goes straight to LOAD instead of being stored.
    assign bypass     = (state == ST_IDLE) & fifo_empty & push_acc;
    assign fifo_push  = push_acc & ~bypass;
    assign fifo_pop   = (state == ST_IDLE) & ~fifo_empty;
    assign fifo_clear = (state == ST_RETIRE) & done_valid & done_ready & done_last;
    assign fin_now    = finish | fin_pend;
    assign cnt_next   = cnt + (beat_done ? SIZE_WIDTH'(RR_BEAT_BYTES) : SIZE_WIDTH'(0));
    assign stall      = (state == ST_IDLE) & fifo_empty;

    rr_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (fifo_clear),
        .push  (fifo_push),
        .din   (in_desc),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

    // Scheduler FSM with beat counter, buffer config and completion registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur         <= '0;
            fin_pend    <= 1'b0;
            cnt         <= '0;
            buf_addr    <= '0;
            buf_size    <= '0;
            buf_update  <= 1'b0;
            done_valid  <= 1'b0;
            done_addr   <= '0;
            done_bytes  <= '0;
            done_last   <= 1'b0;
            irq         <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            buf_update <= 1'b0;
            irq        <= 1'b0;
            if (beat_done && state != ST_ACTIVE) begin
                err_overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur      <= head;
                        fin_pend <= fin_now;
                        state    <= ST_LOAD;
                    end else if (bypass) begin
                        cur      <= in_desc;
                        fin_pend <= fin_now;
                        state    <= ST_LOAD;
                    end else if (fin_now) begin
                        done_addr  <= '0;
                        done_bytes <= '0;
                        done_last  <= 1'b1;
                        done_valid <= 1'b1;
                        fin_pend   <= 1'b0;
                        state      <= ST_RETIRE;
                    end
                end
                ST_LOAD: begin
                    buf_addr <= ADDR_WIDTH'(cur.addr);
                    buf_size <= SIZE_WIDTH'(cur.size);
                    cnt      <= '0;
                    if (cur.size == '0) begin
                        done_addr  <= ADDR_WIDTH'(cur.addr);
                        done_bytes <= '0;
                        done_last  <= fin_now;
                        done_valid <= 1'b1;
                        fin_pend   <= 1'b0;
                        state      <= ST_RETIRE;
                    end else begin
                        buf_update <= 1'b1;
                        fin_pend   <= fin_now;
                        state      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    cnt <= cnt_next;
                    if (fin_now || cnt_next == buf_size) begin
                        done_addr  <= buf_addr;
                        done_bytes <= cnt_next;
                        done_last  <= fin_now;
                        done_valid <= 1'b1;
                        fin_pend   <= 1'b0;
                        state      <= ST_RETIRE;
                    end
                end
                ST_RETIRE: begin
                    fin_pend <= fin_now;
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        irq        <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
